// File: rtl/debounce_pkg.sv
// ============================================================================
// Module  : debounce_pkg
// Purpose : Shared helpers for the debounce bank: width calculation and the
//           idle key level derived from the key polarity.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package debounce_pkg;

  // Width helper that never returns 0, so a 1-deep counter still gets one bit.
  function automatic int clog2_min1(input int value);
    return ($clog2(value) < 1) ? 1 : $clog2(value);
  endfunction

  // Width of the stability counter for a given DEBOUNCE_CYCLES value.
  function automatic int cnt_width(input int cycles);
    return clog2_min1(cycles + 1);
  endfunction

  // Released (idle) level on the pad: high for active-low keys.
  function automatic logic idle_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage : debounce_pkg

`default_nettype wire

// File: rtl/debounce_chan.sv
// ============================================================================
// Module  : debounce_chan
// Purpose : One debounce channel: 2-FF synchroniser, stability counter,
//           registered press/release pulses and an optional long-press
//           hold counter (compiled in with DEBOUNCE_BANK_LONGPRESS_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_chan
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACTIVE_LOW      = 1,
  parameter int LONG_CYCLES     = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_out,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          IDLE    = idle_level(ACTIVE_LOW != 0);
  localparam logic          PRESSED = ~IDLE;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Two-stage synchroniser; reset to the idle level so no false press appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= IDLE;
      s2 <= IDLE;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

  // Accept s2 only after DEBOUNCE_CYCLES consecutive differing samples; any
  // sample matching the current level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_out     <= IDLE;
      cnt         <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      if (s2 == key_out) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        key_out     <= s2;
        cnt         <= '0;
        key_press   <= (s2 == PRESSED);
        key_release <= (s2 != PRESSED);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef DEBOUNCE_BANK_LONGPRESS_EN
  localparam int            HW       = clog2_min1(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  logic [HW-1:0] hc;

  // Count cycles held pressed, saturating so key_long fires once per press.
  always_ff @(posedge clk) begin
    if (rst) begin
      hc       <= '0;
      key_long <= 1'b0;
    end else if (key_out == PRESSED) begin
      if (hc != HOLD_MAX) begin
        hc       <= hc + HW'(1);
        key_long <= (hc == HOLD_MAX - HW'(1));
      end else begin
        key_long <= 1'b0;
      end
    end else begin
      hc       <= '0;
      key_long <= 1'b0;
    end
  end
`else
  // Long-press hardware not built; parameter kept for a uniform interface.
  logic [31:0] unused_long_cfg;
  assign unused_long_cfg = LONG_CYCLES;
  assign key_long        = 1'b0;
`endif

endmodule : debounce_chan

`default_nettype wire

// File: rtl/debounce_bank.sv
// ============================================================================
// Module  : debounce_bank
// Purpose : N independent key debouncers with settled levels and one-cycle
//           press/release events. Long-press detection is built only when
//           DEBOUNCE_BANK_LONGPRESS_EN is defined; otherwise key_long is 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N               = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACTIVE_LOW      = 1,
  parameter int LONG_CYCLES     = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key_in,
  output logic [N-1:0] key_out,
  output logic [N-1:0] key_press,
  output logic [N-1:0] key_release,
  output logic [N-1:0] key_long
);

  // One self-contained channel per key; the bank only gathers the bits.
  for (genvar i = 0; i < N; i++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in[i]),
      .key_out     (key_out[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i])
    );
  end : g_chan

endmodule : debounce_bank

`default_nettype wire

// File: tb/tb_debounce_bank.sv
// ============================================================================
// Module  : tb_debounce_bank
// Purpose : Self-checking bench for debounce_bank (N=8, DEBOUNCE_CYCLES=4,
//           ACTIVE_LOW=1, LONG_CYCLES=16) with a window-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_bank;

  localparam int N    = 8;
  localparam int D    = 4;
  localparam int LONG = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] key_in;
  logic [N-1:0] key_out, key_press, key_release, key_long;

  int vectors = 0;
  int errors  = 0;

  debounce_bank #(
    .N               (N),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (1),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_out     (key_out),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a key's level changes once its last D synchronised
  // samples all disagree with the accepted level; sync is a 2-deep delay.
  logic [N-1:0] ms1, ms2, mout, mpress, mrel, mlong;
  logic [N-1:0] hist [D];
  int           hold [N];
  bit           model_valid = 1'b0;

  always @(posedge clk) begin
    logic [N-1:0] flip;
    if (rst) begin
      ms1 = '1; ms2 = '1; mout = '1;
      mpress = '0; mrel = '0; mlong = '0;
      for (int j = 0; j < D; j++) hist[j] = '1;
      for (int c = 0; c < N; c++) hold[c] = 0;
      model_valid = 1'b1;
    end else begin
      for (int j = D - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = ms2;
      flip = '1;
      for (int j = 0; j < D; j++) flip &= (hist[j] ^ mout);
      mpress = flip & mout;
      mrel   = flip & ~mout;
      for (int c = 0; c < N; c++) begin
        mlong[c] = 1'b0;
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
        if (mout[c] == 1'b0) begin
          if (hold[c] < LONG) begin
            hold[c]++;
            mlong[c] = (hold[c] == LONG);
          end
        end else begin
          hold[c] = 0;
        end
`endif
      end
      mout = mout ^ flip;
      for (int j = 0; j < D; j++) if (flip != '0) hist[j] = hist[j];
      ms2 = ms1;
      ms1 = key_in;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("key_out",     32'(key_out),     32'(mout));
      check("key_press",   32'(key_press),   32'(mpress));
      check("key_release", 32'(key_release), 32'(mrel));
      check("key_long",    32'(key_long),    32'(mlong));
    end
  end

  // Edges until the selected pulse vector has a bit in mask set (bounded).
  task automatic wait_pulse(input int which, input logic [N-1:0] mask, output int n);
    n = 0;
    while (n < 30) begin
      @(posedge clk); #1;
      n++;
      if (which == 0 && (key_press & mask) != '0) return;
      if (which == 1 && (key_release & mask) != '0) return;
    end
  endtask

  initial begin
    int n, pp, lp, nl, npulse;
    logic [N-1:0] v;

    // Reset with all keys held pressed on the pads.
    rst = 1'b1; key_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_key_out", 32'(key_out), 32'h0000_00FF);
    check("reset_pulses", 32'(key_press | key_release | key_long), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_pulses", 32'(key_press | key_release), 32'h0);
    key_in = 8'hFF;
    repeat (10) @(negedge clk);

    // Single press on channel 0: exact latency and single-cycle pulse.
    key_in[0] = 1'b0;
    wait_pulse(0, 8'h01, n);
    check("press0_latency", 32'(n), 32'd6);
    check("press0_level", 32'(key_out[0]), 32'd0);
    @(posedge clk); #1;
    check("press0_one_cycle", 32'(key_press[0]), 32'd0);
    @(negedge clk);
    key_in[0] = 1'b1;
    repeat (10) @(negedge clk);

    // Glitch on channel 3 shorter than the window: no effect.
    key_in[3] = 1'b0;
    repeat (3) @(negedge clk);
    key_in[3] = 1'b1;
    npulse = 0;
    repeat (10) begin
      @(negedge clk);
      if (key_press[3] || key_release[3] || !key_out[3]) npulse++;
    end
    check("glitch3_no_event", 32'(npulse), 32'd0);
    key_in[3] = 1'b0;
    wait_pulse(0, 8'h08, n);
    check("press3_full_count", 32'(n), 32'd6);
    @(negedge clk);
    key_in[3] = 1'b1;
    repeat (10) @(negedge clk);

    // All channels at once.
    key_in = 8'h00;
    wait_pulse(0, 8'hFF, n);
    check("all_press", 32'(key_press), 32'h0000_00FF);
    @(negedge clk);
    key_in = 8'hFF;
    wait_pulse(1, 8'hFF, n);
    check("all_release", 32'(key_release), 32'h0000_00FF);
    repeat (3) @(negedge clk);

    // Reset while channel 2 is mid-count.
    key_in[2] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_mid_count", 32'(key_out[2]), 32'd1);
    wait_pulse(0, 8'h04, n);
    check("press2_after_reset", 32'(n), 32'd6);
    @(negedge clk);
    key_in[2] = 1'b1;
    repeat (10) @(negedge clk);

    // Long hold on channel 5.
    key_in[5] = 1'b0;
    pp = -1; lp = -1; nl = 0;
    for (int i = 0; i < 46; i++) begin
      @(posedge clk); #1;
      if (key_press[5]) pp = i;
      if (key_long[5]) begin nl++; lp = i; end
    end
`ifdef DEBOUNCE_BANK_LONGPRESS_EN
    check("long5_count", 32'(nl), 32'd1);
    check("long5_delay", 32'(lp - pp), 32'd16);
`else
    check("long5_count", 32'(nl), 32'd0);
`endif
    @(negedge clk);
    key_in[5] = 1'b1;
    repeat (10) @(negedge clk);

    // Randomised bursts: alternating noisy and calm phases, rare resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      v = key_in;
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, ((i / 200) % 2 == 0) ? 2 : 11) == 0) v[c] = ~v[c];
      key_in = v;
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_debounce_bank

`default_nettype wire
